siso_shift_reg: RTL and testbench

Parameterised serial-in/serial-out shift register with run-time selectable shift direction. One bit enters on `sin` every rising clock edge and leaves on `sout` WIDTH clocks later. Used as a fixed-length serial delay line or bit-reordering stage between serial links. The RTL module is `siso_shift_reg`.

---
 rtl/siso_shift_reg.sv | 82 ++++++++
 tb/tb_siso_shift_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/siso_shift_reg.sv
// siso_shift_reg: serial-in/serial-out shift register. The shift direction is
// selectable at run time and sampled on every rising clock edge.
//
// A bit sampled on sin_i leaves on sout_o WIDTH clock periods later.
// There is no hold or enable: the register shifts on every rising edge
// while reset is released.
//
// Optional feature: define SISO_STATUS_EN to add the q_o / full_o status
// ports and the saturating fill counter behind full_o.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_ni       asynchronous active-low reset; clears the register (and counter)
//   direction_i  1 = shift toward MSB, 0 = shift toward LSB
//   sin_i        serial data in
//   sout_o       serial data out (MSB end when shifting left, LSB end when right)
//   q_o          (SISO_STATUS_EN) current register contents
//   full_o       (SISO_STATUS_EN) high once WIDTH shifts have occurred since reset

module siso_shift_reg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             direction_i,
   input  logic             sin_i,
`ifdef SISO_STATUS_EN
   output logic [WIDTH-1:0] q_o,
   output logic             full_o,
`endif
   output logic             sout_o
);

   logic [WIDTH-1:0] r_q, r_d;

   always_comb begin
      r_d = r_q;
      if (direction_i) begin
         r_d = {r_q[WIDTH-2:0], sin_i};
      end else begin
         r_d = {sin_i, r_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   // Output end follows direction immediately; there is no path from sin_i.
   assign sout_o = direction_i ? r_q[WIDTH-1] : r_q[0];

`ifdef SISO_STATUS_EN
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Saturates at WIDTH; a direction change does not restart the fill count.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q_o    = r_q;
   assign full_o = (cnt_q == CntMax);
`endif

endmodule

// File: tb/tb_siso_shift_reg.sv
// Scoreboard bench for siso_shift_reg. The driver applies one input pair per
// clock, advances a bit-vector reference model and queues the expected
// outputs; a monitor compares them on the falling edge.

module tb_siso_shift_reg;

   localparam int unsigned W = 4;

   logic clk_i;
   logic rst_ni;
   logic direction_i;
   logic sin_i;
   logic sout_o;
`ifdef SISO_STATUS_EN
   logic [W-1:0] q_o;
   logic         full_o;
`endif

   siso_shift_reg #(
      .WIDTH(W)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .direction_i(direction_i),
      .sin_i      (sin_i),
`ifdef SISO_STATUS_EN
      .q_o        (q_o),
      .full_o     (full_o),
`endif
      .sout_o     (sout_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        s;
      logic        f;
      logic [63:0] q;
   } exp_t;

   exp_t exp_q[$];

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: register contents as a plain vector plus a shift count.
   logic [63:0] m;
   int          shifts;
   logic [63:0] mask;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_shift(input logic d, input logic s);
      if (d) begin
         m = ((m << 1) | {63'd0, s}) & mask;
      end else begin
         m = (m >> 1) | ({63'd0, s} << (W - 1));
      end
      shifts++;
   endtask

   function automatic exp_t expect_now(input logic d);
      exp_t e;
      e.s = d ? m[W-1] : m[0];
      e.f = (shifts >= W);
      e.q = m;
      return e;
   endfunction

   // One clock: the edge consumes the inputs currently applied, then the next
   // pair is applied and the outputs expected before the following edge queued.
   task automatic step(input logic d, input logic s);
      @(posedge clk_i);
      #1;
      if (rst_ni) model_shift(direction_i, sin_i);
      direction_i = d;
      sin_i       = s;
      #1;
      exp_q.push_back(expect_now(d));
   endtask

   // Reset pulse between edges; outputs must clear with no clock edge.
   task automatic do_reset();
      @(negedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("async_reset_sout", {63'd0, sout_o}, 64'd0);
`ifdef SISO_STATUS_EN
      chk("async_reset_q", {{(64-W){1'b0}}, q_o}, 64'd0);
      chk("async_reset_full", {63'd0, full_o}, 64'd0);
`endif
      m      = '0;
      shifts = 0;
      #1;
      rst_ni = 1'b1;
   endtask

   // Monitor: sout_o is always valid, so compare whenever an expectation waits.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sout", {63'd0, sout_o}, {63'd0, e.s});
`ifdef SISO_STATUS_EN
            chk("q", {{(64-W){1'b0}}, q_o}, e.q);
            chk("full", {63'd0, full_o}, {63'd0, e.f});
`endif
         end
      end
   end

   initial begin
      logic d;
      mask        = {64{1'b1}} >> (64 - W);
      m           = '0;
      shifts      = 0;
      rst_ni      = 1'b0;
      direction_i = 1'b1;
      sin_i       = 1'b1;
      #1;
      chk("reset_sout", {63'd0, sout_o}, 64'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      // Fill with ones, then reset mid-stream with sout_o high.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
      do_reset();

      // Left shift of 1,0,0,0.
      direction_i = 1'b1;
      sin_i       = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

      // Alternating stream.
      for (int i = 0; i < 10; i++) step(1'b1, logic'(i % 2));

      // Load 1100, then flip direction between edges and shift a 1 in.
      for (int i = 0; i < 4; i++) step(1'b1, logic'(i < 2));
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // Right shift of 1,0,0,0 from a clean register.
      do_reset();
      direction_i = 1'b0;
      sin_i       = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

      // Random traffic with occasional direction flips and resets.
      d = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) d = ~d;
         step(d, logic'($urandom_range(0, 1)));
         if ($urandom_range(0, 49) == 0) do_reset();
      end

      repeat (3) @(negedge clk_i);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
